// File: rtl/motoro3_gate_monitor.sv
// Observe-only checker for the six gate-drive lines: shoot-through and dead-time faults, six-step sector decode, period and direction.
// The input lines are registered once, so status reports 2 cycles after a line event. The block only observes, so it has no backpressure.
module motoro3_gate_monitor #(
  parameter int DEAD_MIN  = 8,
  parameter int FLOAT_CYC = 2000,
  parameter int PERIOD_W  = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aHp,
  input  logic                aLp,
  input  logic                bHp,
  input  logic                bLp,
  input  logic                cHp,
  input  logic                cLp,
  input  logic                clrFault,
  output logic                shootFault,
  output logic                deadFault,
  output logic [2:0]          faultLeg,
  output logic                sectorValid,
  output logic [2:0]          sector,
  output logic                dirRev,
  output logic                seqErr,
  output logic                periodStrobe,
  output logic [PERIOD_W-1:0] stepPeriod,
  output logic                stall
);

  localparam int OFF_W = $clog2(FLOAT_CYC + 1);
  localparam logic [OFF_W-1:0]    FLOAT_MAX = OFF_W'(FLOAT_CYC);
  localparam logic [OFF_W-1:0]    DEAD_LIM  = OFF_W'(DEAD_MIN);
  localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {ON_NONE, ON_H, ON_L} on_e;

  logic [2:0]          hp_q, hp_d, lp_q, lp_d;
  logic [2:0]          hp_prev_q, hp_prev_d, lp_prev_q, lp_prev_d;
  on_e                 last_on_q [3];
  on_e                 last_on_d [3];
  logic [OFF_W-1:0]    off_cnt_q [3];
  logic [OFF_W-1:0]    off_cnt_d [3];
  logic [2:0]          shoot_set, dead_set, h_cls, l_cls;
  logic                dec_vld;
  logic [2:0]          dec_sec, sec_fwd, sec_rev;
  logic                seq_set;

  logic                shoot_q, shoot_d, dead_q, dead_d, seq_q, seq_d;
  logic [2:0]          leg_q, leg_d;
  logic                valid_q, valid_d, dir_q, dir_d, strobe_q, strobe_d;
  logic [2:0]          sector_q, sector_d;
  logic [PERIOD_W-1:0] period_q, period_d, cnt_q, cnt_d;
  logic                have_sec_q, have_sec_d, first_chg_q, first_chg_d;

  // Per-leg tracking and classification on the registered copy of the lines.
  always_comb begin
    hp_d      = {cHp, bHp, aHp};
    lp_d      = {cLp, bLp, aLp};
    hp_prev_d = hp_q;
    lp_prev_d = lp_q;
    shoot_set = '0;
    dead_set  = '0;
    h_cls     = '0;
    l_cls     = '0;
    for (int i = 0; i < 3; i++) begin
      last_on_d[i] = last_on_q[i];
      off_cnt_d[i] = off_cnt_q[i];
      if (hp_q[i] || lp_q[i]) begin
        off_cnt_d[i] = '0;
      end else if (off_cnt_q[i] < FLOAT_MAX) begin
        off_cnt_d[i] = off_cnt_q[i] + OFF_W'(1);
      end
      // An overlap cycle leaves the last conducting side unchanged.
      if (hp_q[i] && !lp_q[i]) begin
        last_on_d[i] = ON_H;
      end else if (lp_q[i] && !hp_q[i]) begin
        last_on_d[i] = ON_L;
      end
      shoot_set[i] = hp_q[i] & lp_q[i];
      dead_set[i]  = (off_cnt_q[i] < DEAD_LIM) &&
                     ((hp_q[i] && !hp_prev_q[i] && last_on_q[i] == ON_L) ||
                      (lp_q[i] && !lp_prev_q[i] && last_on_q[i] == ON_H));
      h_cls[i] = hp_q[i] || (last_on_q[i] == ON_H && off_cnt_q[i] < FLOAT_MAX);
      l_cls[i] = !h_cls[i] && (lp_q[i] || (last_on_q[i] == ON_L && off_cnt_q[i] < FLOAT_MAX));
    end
  end

  always_comb begin
    dec_vld = 1'b1;
    dec_sec = 3'd0;
    case ({h_cls, l_cls})
      6'b001_010: dec_sec = 3'd0;
      6'b001_100: dec_sec = 3'd1;
      6'b010_100: dec_sec = 3'd2;
      6'b010_001: dec_sec = 3'd3;
      6'b100_001: dec_sec = 3'd4;
      6'b100_010: dec_sec = 3'd5;
      default:    dec_vld = 1'b0;
    endcase
  end

  always_comb begin
    sec_fwd     = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
    sec_rev     = (sector_q == 3'd0) ? 3'd5 : sector_q - 3'd1;
    sector_d    = sector_q;
    dir_d       = dir_q;
    seq_set     = 1'b0;
    strobe_d    = 1'b0;
    period_d    = period_q;
    have_sec_d  = have_sec_q;
    first_chg_d = first_chg_q;
    valid_d     = dec_vld;
    cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + PERIOD_W'(1);
    if (dec_vld) begin
      if (!have_sec_q) begin
        sector_d   = dec_sec;
        have_sec_d = 1'b1;
      end else if (dec_sec != sector_q) begin
        if (dec_sec == sec_fwd) begin
          dir_d = 1'b0;
        end else if (dec_sec == sec_rev) begin
          dir_d = 1'b1;
        end else begin
          seq_set = 1'b1;
        end
        // The first change after reset only starts the period measurement.
        if (first_chg_q) begin
          period_d = cnt_q;
          strobe_d = 1'b1;
        end
        first_chg_d = 1'b1;
        cnt_d       = PERIOD_W'(1);
        sector_d    = dec_sec;
      end
    end
  end

  // A clear and a new fault in the same cycle leave the flag set.
  always_comb begin
    shoot_d = (shoot_q & ~clrFault) | (|shoot_set);
    dead_d  = (dead_q & ~clrFault) | (|dead_set);
    leg_d   = (leg_q & {3{~clrFault}}) | shoot_set | dead_set;
    seq_d   = (seq_q & ~clrFault) | seq_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hp_q        <= '0;
      lp_q        <= '0;
      hp_prev_q   <= '0;
      lp_prev_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        last_on_q[i] <= ON_NONE;
        off_cnt_q[i] <= '0;
      end
      shoot_q     <= 1'b0;
      dead_q      <= 1'b0;
      leg_q       <= '0;
      seq_q       <= 1'b0;
      valid_q     <= 1'b0;
      sector_q    <= '0;
      dir_q       <= 1'b0;
      strobe_q    <= 1'b0;
      period_q    <= '0;
      cnt_q       <= '0;
      have_sec_q  <= 1'b0;
      first_chg_q <= 1'b0;
    end else begin
      hp_q        <= hp_d;
      lp_q        <= lp_d;
      hp_prev_q   <= hp_prev_d;
      lp_prev_q   <= lp_prev_d;
      last_on_q   <= last_on_d;
      off_cnt_q   <= off_cnt_d;
      shoot_q     <= shoot_d;
      dead_q      <= dead_d;
      leg_q       <= leg_d;
      seq_q       <= seq_d;
      valid_q     <= valid_d;
      sector_q    <= sector_d;
      dir_q       <= dir_d;
      strobe_q    <= strobe_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      have_sec_q  <= have_sec_d;
      first_chg_q <= first_chg_d;
    end
  end

  assign shootFault   = shoot_q;
  assign deadFault    = dead_q;
  assign faultLeg     = leg_q;
  assign sectorValid  = valid_q;
  assign sector       = sector_q;
  assign dirRev       = dir_q;
  assign seqErr       = seq_q;
  assign periodStrobe = strobe_q;
  assign stepPeriod   = period_q;
  assign stall        = (cnt_q == CNT_MAX);

endmodule

// File: doc/motoro3_gate_monitor.md
Name: motoro3_gate_monitor

Overview:
- Passive observer on the six gate-drive lines (aHp/aLp, bHp/bLp, cHp/cLp) produced by the 3-phase motor drive path.
- Checks the lines for shoot-through and dead-time violations, and decodes which six-step commutation sector is being driven.
- Measures the sector period in clk cycles and reports rotation direction and sequence errors.
- Output feeds the supervisor/regs so it can stop the drive or confirm speed; the block never drives the gates.

Parameters:
- DEAD_MIN, 8: minimum cycles both switches of a leg must be off before the opposite switch turns on.
- FLOAT_CYC, 2000: cycles a leg must stay fully off before it is classed floating (must exceed PWM off-time).
- PERIOD_W, 25: width of the sector-period counter; matches the m3cnt width.

Ports:
- clk  in  1  system clock, 10 MHz.
- rst  in  1  synchronous reset, active-high.
- aHp, aLp, bHp, bLp, cHp, cLp  in  1 each  gate-drive lines (High-side / Low-side switch per phase); same clock domain.
- clrFault  in  1  one-cycle pulse; clears the sticky fault flags.
- shootFault  out  1  sticky; a leg had Hp and Lp high together.
- deadFault  out  1  sticky; dead-time violation seen.
- faultLeg  out  3  sticky per-leg fault record, bit0=A, bit1=B, bit2=C.
- sectorValid  out  1  the current leg classes form a legal six-step pattern.
- sector  out  3  decoded sector 0..5; holds the last valid value.
- dirRev  out  1  0 = forward (sector+1), 1 = reverse (sector-1); updated on each sector change.
- seqErr  out  1  sticky; a sector jump that is not ±1 mod 6.
- periodStrobe  out  1  one-cycle pulse when stepPeriod updates.
- stepPeriod  out  PERIOD_W  cycles between the last two sector changes.
- stall  out  1  period counter is saturated.

Behaviour:
- Inputs are registered once; all checks run on the registered copy, so faults appear 2 cycles after the input event.
- Reset values: every output is 0. Internal state is also cleared: leg classes = float, off counters = 0, period counter = 0, "first change seen" = 0.
- Per leg, tracked every cycle:
  - lastOn ∈ {none, H, L}.
  - offCnt: counts up while Hp=Lp=0 and saturates at FLOAT_CYC; resets to 0 whenever either line is high.
- Shoot-through: if Hp and Lp are both high in the same cycle, set shootFault and the corresponding faultLeg bit.
- Dead time: on a rising edge of Hp when lastOn=L, or a rising edge of Lp when lastOn=H, with offCnt < DEAD_MIN, set deadFault and the faultLeg bit.
  - A re-turn-on of the same side (PWM chopping) is never a dead-time event.
- Leg class:
  - H if Hp high, or lastOn=H and offCnt < FLOAT_CYC.
  - L by the same rule with Lp.
  - Otherwise F (floating).
- Sector map (exactly one leg H, one L, one F):
  - A H, B L → 0.
  - A H, C L → 1.
  - B H, C L → 2.
  - B H, A L → 3.
  - C H, A L → 4.
  - C H, B L → 5.
  - Any other combination → sectorValid=0, and sector holds its previous value.
- Period counter: increments every cycle and saturates at all-ones, with stall=1 while saturated.
- On a valid sector that differs from the held sector:
  - Direction: new = old+1 mod 6 → dirRev=0. new = old−1 mod 6 → dirRev=1. Otherwise seqErr=1 and dirRev is unchanged.
  - If "first change seen"=1: stepPeriod ← counter value, pulse periodStrobe. The first change after reset does not publish a period.
  - Set "first change seen", reset the counter to 1, clear stall.
- The first valid sector after reset is only loaded into sector; it is not treated as a change.
- Wrap: 5→0 is forward and 0→5 is reverse.
- clrFault clears shootFault, deadFault, faultLeg and seqErr.
  - If a fault condition is present in the same cycle, the set wins and the flag remains 1.
- rst mid-operation returns everything to reset values on the next edge. The first valid sector after reset is loaded silently; the first sector change after that publishes no period.

Test Plan:
- Reset, then drive A H-PWM (50% duty, 100-cycle period) with B Lp held high for 5000 cycles → sectorValid=1, sector=0, no faults, stall=0.
- Drive sectors 0→1→2→3, each for 4000 cycles → periodStrobe on the 2nd and 3rd changes only; stepPeriod=4000 both times; dirRev=0; seqErr=0.
- Drive sectors 2→1→0→5 → dirRev=1 after the first change; the 0→5 wrap gives no seqErr.
- Set aHp=aLp=1 for 1 cycle → shootFault=1, faultLeg=001 two cycles later. Pulse clrFault with the lines idle → all flags 0. Pulse clrFault during a persistent overlap → shootFault stays 1.
- On leg B, Hp falls, then Lp rises after 5 cycles (DEAD_MIN=8) → deadFault=1, faultLeg=010. Repeat with an 8-cycle gap → no fault.
- Jump sector 1→4 → seqErr=1. Then hold one sector for 2^25 cycles (or a reduced PERIOD_W) → stall=1. Assert rst mid-run → all outputs 0 on the next edge.
